// File: rtl/uart_pkg.sv
// Shared state encoding, default sizing and index-width helper for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LAUNCH    = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int UART_ARB_NUM_REQ      = 4;
  localparam int UART_ARB_DATA_SIZE    = 8;
  localparam int UART_ARB_TIMEOUT_CLKS = 16;

  function automatic int uart_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: nearest active request above last_grant, wrapping at NUM_REQ.
// Zero latency; pure function of its inputs, no backpressure.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = UART_ARB_NUM_REQ,
  localparam int IW     = uart_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  output logic               any_o,
  output logic [IW-1:0]      winner_o
);

  localparam logic [IW:0] N_W = (IW+1)'(NUM_REQ);

  logic [IW:0] cand;

  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    cand     = '0;
    // Farthest candidate first, so the nearest active one above last_grant overwrites it.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_grant_i} + (IW+1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (req_i[cand[IW-1:0]]) begin
        any_o    = 1'b1;
        winner_o = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; grant/launch registered one cycle after request.
// Holds each grant until tx_busy rises and falls; UART_ARB_TIMEOUT_EN adds a WAIT_BUSY watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = UART_ARB_NUM_REQ,
  parameter int DATA_SIZE    = UART_ARB_DATA_SIZE,
  parameter int TIMEOUT_CLKS = UART_ARB_TIMEOUT_CLKS,
  localparam int IW          = uart_idx_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [DATA_SIZE-1:0]           tx_data,
  input  logic                           tx_busy,
  output logic [IW-1:0]                  grant_id,
  output logic                           arb_busy,
  output logic                           tx_timeout
);

  arb_state_t           state_q;
  logic [IW-1:0]        last_grant_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic                 tx_start_q;
  logic [DATA_SIZE-1:0] tx_data_q;
  logic [IW-1:0]        grant_q;
  logic                 arb_busy_q;

  logic                 pick_any;
  logic [IW-1:0]        pick_winner;
  logic [NUM_REQ-1:0]   req_ready_d;
  logic [DATA_SIZE-1:0] tx_data_d;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_winner)
  );

  assign req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_winner;
  assign tx_data_d   = req_data[pick_winner*DATA_SIZE +: DATA_SIZE];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WW = uart_idx_w(TIMEOUT_CLKS);

  logic [WW-1:0] wdog_q;
  logic          tx_timeout_q;

  assign tx_timeout = tx_timeout_q;
`else
  // Watchdog compiled out: this comparison is constant false for any legal TIMEOUT_CLKS.
  assign tx_timeout = (TIMEOUT_CLKS < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IW'(NUM_REQ-1);
      req_ready_q  <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      grant_q      <= '0;
      arb_busy_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wdog_q       <= '0;
      tx_timeout_q <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tx_timeout_q <= 1'b0;
`endif
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            state_q      <= ARB_LAUNCH;
            last_grant_q <= pick_winner;
            grant_q      <= pick_winner;
            tx_data_q    <= tx_data_d;
            req_ready_q  <= req_ready_d;
            tx_start_q   <= 1'b1;
            arb_busy_q   <= 1'b1;
          end
        end
        ARB_LAUNCH: begin
          state_q <= ARB_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          wdog_q  <= '0;
`endif
        end
        ARB_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= ARB_WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wdog_q == WW'(TIMEOUT_CLKS-1)) begin
            state_q      <= ARB_IDLE;
            arb_busy_q   <= 1'b0;
            tx_timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        ARB_WAIT_DONE: begin
          if (!tx_busy) begin
            state_q    <= ARB_IDLE;
            arb_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_q;
  assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a 4-requester instance plus a 3-requester instance for the odd wrap.
module tb_uart_tx_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        mdl_busy;
  logic        man_busy;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        tx_timeout;

  logic [2:0]  b_valid;
  logic [23:0] b_data;
  logic [2:0]  b_ready;
  logic        b_start;
  logic [7:0]  b_tx_data;
  logic        b_busy;
  logic [1:0]  b_grant;
  logic        b_arb_busy;
  logic        b_timeout;

  logic model_en = 1'b0;

  assign tx_busy = mdl_busy | man_busy;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_SIZE(8), .TIMEOUT_CLKS(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .tx_timeout (tx_timeout)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_SIZE(8), .TIMEOUT_CLKS(TO)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_valid),
    .req_data   (b_data),
    .req_ready  (b_ready),
    .tx_start   (b_start),
    .tx_data    (b_tx_data),
    .tx_busy    (b_busy),
    .grant_id   (b_grant),
    .arb_busy   (b_arb_busy),
    .tx_timeout (b_timeout)
  );

  typedef struct {
    int         id;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t qb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id);
    sb.push_back('{id, req_data[id*8 +: 8]});
  endtask

  task automatic chk_rst_outputs(input string p);
    chk({p, "_ready"},   req_ready,  0);
    chk({p, "_start"},   tx_start,   0);
    chk({p, "_data"},    tx_data,    0);
    chk({p, "_grant"},   grant_id,   0);
    chk({p, "_busy"},    arb_busy,   0);
    chk({p, "_timeout"}, tx_timeout, 0);
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (arb_busy !== 1'b0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk(tag, arb_busy, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic release_busy(input string tag);
    man_busy = 1'b1;
    repeat (2) @(posedge clk);
    #2 man_busy = 1'b0;
    wait_idle(tag);
  endtask

  // Every launch must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        if (sb.size() == 0) begin
          chk("launch_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("grant_id",  grant_id,  e.id);
          chk("tx_data",   tx_data,   e.dat);
          chk("req_ready", req_ready, 32'd1 << e.id);
        end
      end
    end
  end

  // Transmitter model: busy 2 cycles after start, for 10 cycles.
  initial begin
    mdl_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (model_en && tx_start === 1'b1) begin
        repeat (2) @(posedge clk);
        #1 mdl_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 mdl_busy = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    int   n;
    int   pulses;
    int   at_k;
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    man_busy  = 1'b0;
    b_valid   = '0;
    b_data    = '0;
    b_busy    = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk_rst_outputs("reset");

    // Reset release straight into a single request.
    model_en  = 1'b1;
    req_data  = {8'h33, 8'h22, 8'h11, 8'hA5};
    req_valid = 4'b0001;
    rst       = 1'b1;
    push_exp(0);
    @(posedge clk); #2;
    chk("first_ready", req_ready, 4'b0001);
    chk("first_start", tx_start,  1);
    chk("first_data",  tx_data,   8'hA5);
    chk("first_grant", grant_id,  0);
    chk("first_busy",  arb_busy,  1);
    req_valid = '0;
    @(posedge clk); #2;
    chk("start_pulse_width", tx_start, 0);
    chk("ready_pulse_width", req_ready, 0);
    wait_idle("idle_first");

    // All requesters held: rotation 0,1,2,3,0.
    apply_reset();
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    req_valid = 4'b1111;
    wait_sb("rotate_drain");
    req_valid = '0;
    wait_idle("idle_rotate");

    // last_grant=3 with 1010: wrap to 1, then 3, then 1.
    apply_reset();
    req_data = {8'h4D, 8'h4C, 8'h4B, 8'h4A};
    push_exp(1); push_exp(3); push_exp(1);
    req_valid = 4'b1010;
    wait_sb("wrap_drain");
    req_valid = '0;
    wait_idle("idle_wrap");

    // Single requester served back-to-back.
    push_exp(2); push_exp(2); push_exp(2);
    req_valid = 4'b0100;
    wait_sb("single_drain");
    req_valid = '0;
    wait_idle("idle_single");

    // Reset during WAIT_DONE aborts cleanly; requester 2 then wins.
    model_en  = 1'b0;
    req_data  = {8'h77, 8'h66, 8'h55, 8'h44};
    req_valid = 4'b0001;
    push_exp(0);
    wait_sb("abort_launch");
    man_busy  = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("wait_done_busy", arb_busy, 1);
    rst       = 1'b0;
    req_valid = 4'b1111;
    @(posedge clk); #2;
    chk_rst_outputs("midrst");
    rst       = 1'b1;
    man_busy  = 1'b0;
    req_valid = 4'b0100;
    push_exp(2);
    wait_sb("post_rst_grant");
    req_valid = '0;
    release_busy("idle_post_rst");

    // Transmitter never responds.
    req_valid = 4'b0001;
    push_exp(0);
    wait_sb("stuck_launch");
    req_valid = '0;
    pulses = 0;
    at_k   = 0;
    for (int k = 1; k <= TO + 3; k++) begin
      @(posedge clk); #2;
      if (tx_timeout === 1'b1) begin
        pulses++;
        at_k = k;
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
    chk("timeout_pulses", pulses, 1);
    chk("timeout_cycle",  at_k,   TO + 1);
    chk("timeout_idle",   arb_busy, 0);
`else
    chk("no_timeout_pulses", pulses, 0);
    chk("stuck_wait_busy",   arb_busy, 1);
    release_busy("idle_stuck");
`endif

    // Three requesters: rotation 0,1,2,0 with exact wrap.
    b_data  = {8'hB2, 8'hB1, 8'hB0};
    qb.push_back('{0, 8'hB0});
    qb.push_back('{1, 8'hB1});
    qb.push_back('{2, 8'hB2});
    qb.push_back('{0, 8'hB0});
    b_valid = 3'b111;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (b_start !== 1'b1 && n < 40) begin
        @(posedge clk); #2;
        n++;
      end
      chk("b_launch", b_start, 1);
      if (b_start === 1'b1 && qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_grant", b_grant,   e.id);
        chk("b_data",  b_tx_data, e.dat);
        chk("b_ready", b_ready,   32'd1 << e.id);
      end
      if (g == 3) b_valid = '0;
      b_busy = 1'b1;
      repeat (3) @(posedge clk);
      #2 b_busy = 1'b0;
    end

    chk("sb_left", sb.size(), 0);
    chk("qb_left", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_SIZE, default 8: character width in bits (5..9).
REQ-003 Parameter TIMEOUT_CLKS, default 16: clocks allowed between tx_start and tx_busy rising.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  requester i has a character pending; held with req_data until accepted.
REQ-007 req_data  input  NUM_REQ*DATA_SIZE  character of requester i in slice [i*DATA_SIZE +: DATA_SIZE].
REQ-008 req_ready  output  NUM_REQ  one-hot accept pulse; transfer occurs on a cycle with req_valid[i] && req_ready[i].
REQ-009 tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-010 tx_data  output  DATA_SIZE  character presented to the transmitter; stable from tx_start until return to IDLE.
REQ-011 tx_busy  input  1  transmitter busy flag, including stop bits.
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of the requester currently being served.
REQ-013 arb_busy  output  1  high in every state except IDLE.
REQ-014 tx_timeout  output  1  one-cycle pulse when a launch is aborted.

Function
REQ-015 States SHALL be IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE; all outputs are registered.
REQ-016 IDLE: when any req_valid is high at cycle t, the block SHALL select winner w round-robin, searching upward from last_grant+1 and wrapping modulo NUM_REQ.
REQ-017 At t+1 the block SHALL be in LAUNCH with tx_data=req_data[w], grant_id=w, req_ready[w]=1 and tx_start=1, each pulse lasting exactly one cycle; last_grant SHALL be set to w.
REQ-018 LAUNCH SHALL always advance to WAIT_BUSY on the next cycle.
REQ-019 WAIT_BUSY SHALL advance to WAIT_DONE on the first cycle tx_busy=1.
REQ-020 WAIT_DONE SHALL return to IDLE on the first cycle tx_busy=0; a new grant is issued no earlier than the following cycle.
REQ-021 Requests arriving or dropping outside IDLE SHALL be ignored; req_valid deasserted before req_ready is a legal withdrawal and forfeits the slot.
REQ-022 A single active requester SHALL be served back-to-back with no starvation check; with all requesters active, grants SHALL rotate 0,1,..,NUM_REQ-1,0.
REQ-023 The search-and-wrap arithmetic SHALL use $clog2(NUM_REQ) bits plus one guard bit; the wrap from NUM_REQ-1 to 0 SHALL be exact for non-power-of-two NUM_REQ.

Reset
REQ-024 While rst=0 at a rising edge: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, tx_timeout=0, last_grant=NUM_REQ-1 (so requester 0 wins first), watchdog=0.
REQ-025 Reset asserted mid-operation SHALL abort the transfer without issuing any req_ready or tx_start pulse in that cycle.

Configuration
REQ-026 Macro UART_ARB_TIMEOUT_EN defined: a watchdog SHALL count cycles in WAIT_BUSY; at count TIMEOUT_CLKS-1 without tx_busy, the block SHALL return to IDLE with a one-cycle tx_timeout pulse.
REQ-027 Macro UART_ARB_TIMEOUT_EN undefined: no watchdog logic, tx_timeout tied 0, and WAIT_BUSY waits indefinitely.

Structure
REQ-028 Package uart_pkg SHALL hold the arb_state_t enum and default constants (UART_ARB_NUM_REQ, UART_ARB_TIMEOUT_CLKS).
REQ-029 Round-robin selection SHALL be a combinational sub-module uart_rr_picker (inputs: req vector, last_grant; outputs: any, winner).

Verification
REQ-030 Reset release with req_valid=4'b0001, data 8'hA5: at t+1, req_ready=4'b0001, tx_start=1, tx_data=8'hA5, grant_id=0.
REQ-031 req_valid=4'b1111 held, with the transmitter model asserting busy 2 cycles after start for 10 cycles: grant_id sequence is 0,1,2,3,0.
REQ-032 last_grant=3, req_valid=4'b1010: next grant is 1 (wrap past 3), followed by 3.
REQ-033 UART_ARB_TIMEOUT_EN defined, tx_busy stuck 0: tx_timeout pulses exactly once, TIMEOUT_CLKS cycles after entry to WAIT_BUSY, then the block returns to IDLE; with the macro undefined it remains in WAIT_BUSY.
REQ-034 rst=0 applied during WAIT_DONE: on the next cycle all outputs are at reset values, and a subsequent single request from requester 2 is granted (last_grant reset).
REQ-035 NUM_REQ=3 with all requesters active: grants follow 0,1,2,0 with no illegal index 3.
